// File: rtl/asic_pkg.sv
// asic_pkg: shared types and constants for the ASIC feed DMA.
// Provides the AXI field widths (as overridable defines), the DMA FSM state
// enum, AXI encodings used by the read master and a small min helper.
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

package asic_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        AR_REQ = 3'd1,
        R_DATA = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } dma_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         BOUNDARY_4K    = 4096;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock word FIFO.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_push/i_wdata write;
// i_pop read-advance; i_flush drops all contents; o_rdata head word (0 when
// empty); o_full/o_empty status; o_count occupancy for free-slot checks.
// A push while full is honoured only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    // Gate the head so the stream output reads 0 while nothing is held.
    assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/asic_feed_dma.sv
// asic_feed_dma: AXI4 read-master DMA feeding the ASIC ingest stream.
// Ports: ACLK/ARESETn clock and async active-low reset; start/src_addr/
// word_cnt job launch; busy/done job status; AR*_M / R*_M AXI4 read master;
// data_out/data_valid/data_ready word stream toward the ASIC.
// Optional macro ASIC_FEED_DMA_ERR_EN adds a sticky `err` output: a non-OKAY
// R beat stops pushing, the burst is drained from the bus, the FIFO is
// flushed and the job ends.
module asic_feed_dma
    import asic_pkg::*;
#(
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 32,
    parameter int CNT_W      = 11
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic                       start,
    input  logic [`AXI_ADDR_BITS-1:0]  src_addr,
    input  logic [CNT_W-1:0]           word_cnt,
    output logic                       busy,
    output logic                       done,
`ifdef ASIC_FEED_DMA_ERR_EN
    output logic                       err,
`endif
    output logic [`AXI_ID_BITS-1:0]    ARID_M,
    output logic [`AXI_ADDR_BITS-1:0]  ARADDR_M,
    output logic [`AXI_LEN_BITS-1:0]   ARLEN_M,
    output logic [`AXI_SIZE_BITS-1:0]  ARSIZE_M,
    output logic [1:0]                 ARBURST_M,
    output logic                       ARVALID_M,
    input  logic                       ARREADY_M,
    input  logic [`AXI_ID_BITS-1:0]    RID_M,
    input  logic [`AXI_DATA_BITS-1:0]  RDATA_M,
    input  logic [1:0]                 RRESP_M,
    input  logic                       RLAST_M,
    input  logic                       RVALID_M,
    output logic                       RREADY_M,
    output logic [31:0]                data_out,
    output logic                       data_valid,
    input  logic                       data_ready
);

    localparam int AB = `AXI_ADDR_BITS;
    localparam int LW = `AXI_LEN_BITS;
    localparam int CW = $clog2(FIFO_DEPTH);

    dma_state_e        r_state;
    dma_state_e        w_next;
    logic [AB-1:0]     r_addr;      // next burst start address
    logic [CNT_W-1:0]  r_remain;    // words not yet requested
    logic [CNT_W-1:0]  r_len;       // length of the burst on AR
    logic              r_arvalid;
    logic [AB-1:0]     r_araddr;
    logic [LW-1:0]     r_arlen;
    logic              r_live;      // lets constant AR fields read 0 in reset

    logic [CNT_W-1:0]  w_to4k;
    logic [CNT_W-1:0]  w_len;
    logic [CNT_W-1:0]  w_free;
    logic [CW:0]       w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic              w_rbeat;
    logic              w_ar_hs;
    logic              w_abort;
    logic              w_accept;

    assign w_rbeat  = RVALID_M && RREADY_M;
    assign w_ar_hs  = r_arvalid && ARREADY_M;
    assign w_pop    = data_valid && data_ready;
    assign w_accept = (r_state == IDLE) && start;
    assign w_free   = CNT_W'(FIFO_DEPTH) - CNT_W'(w_count);
    // Words left before the next 4KB page: 1..1024.
    assign w_to4k   = CNT_W'(BOUNDARY_4K / 4) - CNT_W'(r_addr[11:2]);

    always_comb begin
        w_len = CNT_W'(BURST_LEN);
        if (r_remain < w_len) w_len = r_remain;
        if (w_to4k < w_len)   w_len = w_to4k;
    end

`ifdef ASIC_FEED_DMA_ERR_EN
    logic r_err;
    logic r_drop;   // error seen: swallow the rest of the burst
    logic w_bad;
    assign w_bad   = (RRESP_M != AXI_RESP_OKAY);
    assign w_push  = w_rbeat && !r_drop && !w_bad;
    assign w_abort = w_rbeat && RLAST_M && (r_drop || w_bad);
    assign w_flush = w_abort;
    assign err     = r_err;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_err  <= 1'b0;
            r_drop <= 1'b0;
        end else if (w_accept) begin
            r_err  <= 1'b0;
            r_drop <= 1'b0;
        end else begin
            if (w_rbeat && w_bad) begin
                r_err  <= 1'b1;
                r_drop <= 1'b1;
            end
            if (w_abort) r_drop <= 1'b0;
        end
    end

    logic w_unused;
    assign w_unused = ^{RID_M, w_full};
`else
    assign w_push  = w_rbeat;
    assign w_abort = 1'b0;
    assign w_flush = 1'b0;

    logic w_unused;
    assign w_unused = ^{RID_M, RRESP_M, w_full};
`endif

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (ACLK),
        .i_rst_n (ARESETn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_wdata (RDATA_M[31:0]),
        .o_rdata (data_out),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign data_valid = !w_empty;

    // State register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        done     = 1'b0;
        RREADY_M = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) w_next = (word_cnt != '0) ? AR_REQ : DONE;
            end
            AR_REQ: begin
                busy = 1'b1;
                if (w_ar_hs) w_next = R_DATA;
            end
            R_DATA: begin
                busy     = 1'b1;
                RREADY_M = 1'b1;
                if (w_rbeat && RLAST_M) begin
                    if (w_abort)              w_next = DONE;
                    else if (r_remain != '0)  w_next = AR_REQ;
                    else                      w_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (w_empty) w_next = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Address/count bookkeeping and AR channel
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_addr    <= '0;
            r_remain  <= '0;
            r_len     <= '0;
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_live    <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_accept) begin
                r_addr   <= src_addr;
                r_remain <= word_cnt;
            end
            // Only request once the whole burst fits; the FIFO only drains
            // while waiting, so the check cannot go stale.
            if ((r_state == AR_REQ) && !r_arvalid && (w_free >= w_len)) begin
                r_arvalid <= 1'b1;
                r_araddr  <= r_addr;
                r_arlen   <= LW'(w_len - CNT_W'(1));
                r_len     <= w_len;
            end
            if (w_ar_hs) begin
                r_arvalid <= 1'b0;
                r_addr    <= r_addr + AB'({r_len, 2'b00});
                r_remain  <= r_remain - r_len;
            end
        end
    end

    assign ARID_M    = '0;
    assign ARADDR_M  = r_araddr;
    assign ARLEN_M   = r_arlen;
    assign ARVALID_M = r_arvalid;
    assign ARSIZE_M  = r_live ? AXI_SIZE_WORD  : '0;
    assign ARBURST_M = r_live ? AXI_BURST_INCR : '0;

endmodule

// File: doc/asic_feed_dma.md
Name: asic_feed_dma

Overview:
- AXI4 read-master DMA that fetches the ASIC input tensor (ifmap + weights, 32-bit words) from system memory and streams it word-by-word into the ASIC wrapper's data path.
- Replaces CPU MMIO writes to the data register.
- Sits between the AXI interconnect (master port) and the ASIC data-ingest stream.
- Raises done when the last word has been accepted downstream.

Parameters:
- BURST_LEN, 16, maximum beats per AR burst (1..16).
- FIFO_DEPTH, 32, internal word FIFO depth (power of 2, >= BURST_LEN).
- CNT_W, 11, width of word-count config (max 2047 words; the nominal job is 1104).

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches src_addr and word_cnt.
- src_addr  in  `AXI_ADDR_BITS  word-aligned source byte address.
- word_cnt  in  CNT_W  number of 32-bit words to transfer.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at completion.
- ARID_M  out  `AXI_ID_BITS  constant 0.
- ARADDR_M  out  `AXI_ADDR_BITS  burst start address.
- ARLEN_M  out  `AXI_LEN_BITS  beats-1.
- ARSIZE_M  out  `AXI_SIZE_BITS  constant 3'b010.
- ARBURST_M  out  2  constant INCR.
- ARVALID_M  out  1.
- ARREADY_M  in  1.
- RID_M  in  `AXI_ID_BITS  ignored.
- RDATA_M  in  `AXI_DATA_BITS.
- RRESP_M  in  2.
- RLAST_M  in  1.
- RVALID_M  in  1.
- RREADY_M  out  1.
- data_out  out  32  stream word to ASIC.
- data_valid  out  1  data_out valid.
- data_ready  in  1  ASIC accepts word.

Behaviour:
- Reset (async assert, sync release) clears the following to 0: all outputs, the FIFO pointers, the remaining/issued counters and the state register; state returns to IDLE.
- FSM states IDLE, AR_REQ, R_DATA, DRAIN, DONE.
- IDLE
  - start with word_cnt>0 → AR_REQ; busy=1.
  - start with word_cnt==0 → DONE directly.
  - start while busy is ignored.
- AR_REQ
  - Burst length = min(BURST_LEN, words not yet requested, words to the next 4KB boundary).
  - ARVALID_M is asserted only when FIFO free slots >= that length, so R beats can never overflow the FIFO.
  - ARVALID_M, once high, holds with stable ARADDR_M/ARLEN_M until ARREADY_M.
  - Handshake → R_DATA; next address += len*4.
- R_DATA
  - RREADY_M=1 in this state; beats are pushed on RVALID_M&&RREADY_M.
  - Beat with RLAST_M: if words remain unrequested → AR_REQ, else → DRAIN.
  - Only one outstanding burst at a time.
- DRAIN: wait until FIFO empty and no stream handshake is pending → DONE.
- DONE: done=1 for exactly one cycle, busy=0 → IDLE.
- Stream side
  - data_valid = FIFO non-empty; data_out = FIFO head (registered FIFO, first-word latency 1 cycle after push).
  - Pop on data_valid&&data_ready.
  - data_out is held stable while data_valid && !data_ready.
- Simultaneous push and pop in one cycle keeps the occupancy unchanged; a push is legal when the FIFO is full only if a pop happens in the same cycle (prevented by the AR gating).
- Counters use CNT_W bits; remaining-word count never underflows (len is clamped).
- start pulses arriving during DONE are ignored.

Optional Feature:
- Macro ASIC_FEED_DMA_ERR_EN.
- When defined:
  - Any R beat with RRESP_M != OKAY sets a sticky err output (extra 1-bit port `err`).
  - The FSM finishes accepting the current burst (RREADY held) without pushing the remaining beats, flushes the FIFO and goes to DONE.
  - done pulses and err stays high until the next accepted start.
- When not defined: RRESP_M is ignored, there is no err port, and the data is pushed regardless of RRESP_M.

Decomposition:
- Shared package asic_pkg:
  - dma_state_e enum.
  - AXI_BURST_INCR = 2'b01.
  - AXI_SIZE_WORD = 3'b010.
  - AXI_RESP_OKAY.
  - BOUNDARY_4K = 4096.
- Sub-module sync_fifo (parameterised WIDTH, DEPTH) with push, pop, full, empty and a count output used for the free-slot check.

Test Plan:
- start, src_addr=0x1000_0000, word_cnt=1104, memory word i = i, data_ready always 1:
  - 69 AR bursts of ARLEN=15.
  - data_out sequence 0..1103 in order.
  - One done pulse.
  - busy low after done.
- word_cnt=20, src_addr=0x1000_0FF0:
  - First burst ARLEN=3 (4KB clamp).
  - Second burst ARADDR=0x1000_1000, ARLEN=15.
- Backpressure: data_ready toggles 1-cycle on / 3-cycles off, word_cnt=64:
  - No AR issued while free slots < 16.
  - No data lost or duplicated.
  - data_out stable during stalls.
- word_cnt=0 start → done pulse 1 cycle after IDLE→DONE, no ARVALID_M ever asserted.
- ARESETn asserted mid-burst (after 5 beats of burst 2) → all outputs 0 immediately; after release a new start of 8 words completes correctly.
- ERR_EN build: RRESP_M=SLVERR on beat 3 of the first burst, word_cnt=32:
  - Only beats 0-2 appear on data_out (unless already flushed).
  - err=1; done pulses after the burst's RLAST.
  - Next start clears err.
